// File: rtl/axis_keep_packer.sv
// axis_keep_packer: compacts sparse/partial AXI-Stream beats into dense,
// low-aligned output beats. Only the final beat of a packet may be partial.
// Optional statistics counters are built when AXIS_KEEP_PACKER_STATS_EN is defined.
module axis_keep_packer #(
  parameter int DW = 16,
  parameter int KW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_tvalid,
  input  logic [DW-1:0] s_tdata,
  input  logic [KW-1:0] s_tkeep,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic          m_tvalid,
  output logic [DW-1:0] m_tdata,
  output logic [KW-1:0] m_tkeep,
  output logic          m_tlast,
  input  logic          m_tready
`ifdef AXIS_KEEP_PACKER_STATS_EN
  ,
  output logic [31:0]   pkt_count,
  output logic [31:0]   byte_count
`endif
);

  // Residue count holds 0..KW-1; merged byte total holds 0..2*KW-1.
  localparam int CW = (KW > 1) ? $clog2(KW) : 1;
  localparam int TW = $clog2(2 * KW);

  typedef enum logic {ACC, LAST} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] res_q, res_d;
  logic          m_tvalid_d, m_tlast_d;
  logic [DW-1:0] m_tdata_d;
  logic [KW-1:0] m_tkeep_d;
  logic          out_free;
  logic          accept;
  logic [2*DW-1:0] merged;
  logic [TW-1:0]   total;

  // Keep mask with the low n lanes set.
  function automatic logic [KW-1:0] low_keep(input logic [TW-1:0] n);
    logic [KW-1:0] k;
    for (int i = 0; i < KW; i++) k[i] = (TW'(i) < n);
    return k;
  endfunction

  // Handshake qualifiers; input is only taken in ACC with a free output slot.
  always_comb begin
    out_free = !m_tvalid || m_tready;
    s_tready = rst && out_free && (state_q == ACC);
    accept   = s_tvalid && s_tready;
  end

  // Append kept input lanes, lowest lane first, after the residue bytes.
  always_comb begin
    merged = {{DW{1'b0}}, res_q};
    total  = TW'(cnt_q);
    for (int i = 0; i < KW; i++) begin
      if (s_tkeep[i]) begin
        merged = merged | ({{(2*DW-8){1'b0}}, s_tdata[8*i +: 8]} << {total, 3'b000});
        total  = total + TW'(1);
      end
    end
  end

  // Next-state and output-register load decisions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    m_tvalid_d = m_tvalid;
    m_tdata_d  = m_tdata;
    m_tkeep_d  = m_tkeep;
    m_tlast_d  = m_tlast;
    if (out_free) m_tvalid_d = 1'b0;
    case (state_q)
      ACC: begin
        if (accept) begin
          if (total >= TW'(KW)) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = merged[DW-1:0];
            m_tkeep_d  = '1;
            m_tlast_d  = s_tlast && (total == TW'(KW));
            cnt_d      = CW'(total - TW'(KW));
            res_d      = merged[2*DW-1:DW];
            if (s_tlast && (total > TW'(KW))) state_d = LAST;
          end else if (s_tlast) begin
            // Short or empty tail; an empty one becomes a keep-0 terminator.
            m_tvalid_d = 1'b1;
            m_tdata_d  = merged[DW-1:0];
            m_tkeep_d  = low_keep(total);
            m_tlast_d  = 1'b1;
            cnt_d      = '0;
            res_d      = '0;
          end else begin
            cnt_d = CW'(total);
            res_d = merged[DW-1:0];
          end
        end
      end
      LAST: begin
        if (out_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = res_q;
          m_tkeep_d  = low_keep(TW'(cnt_q));
          m_tlast_d  = 1'b1;
          cnt_d      = '0;
          res_d      = '0;
          state_d    = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State, residue and registered output beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ACC;
      cnt_q    <= '0;
      res_q    <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      m_tvalid <= m_tvalid_d;
      m_tdata  <= m_tdata_d;
      m_tkeep  <= m_tkeep_d;
      m_tlast  <= m_tlast_d;
    end
  end

`ifdef AXIS_KEEP_PACKER_STATS_EN
  logic [31:0] keep_pop;

  // Number of bytes carried by the current output beat.
  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < KW; i++) keep_pop = keep_pop + 32'(m_tkeep[i]);
  end

  // Packet and byte counters advance on each output handshake, wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_count  <= '0;
      byte_count <= '0;
    end else if (m_tvalid && m_tready) begin
      byte_count <= byte_count + keep_pop;
      if (m_tlast) pkt_count <= pkt_count + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_axis_keep_packer.sv
// tb_axis_keep_packer: table vectors, hand-written corner sequences and a
// randomized run against a byte-queue reference model (DW=16, KW=2).
module tb_axis_keep_packer;
  localparam int DW = 16;
  localparam int KW = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  typedef struct {
    int               nbeats;
    logic [1:0][15:0] in_d;
    logic [1:0][1:0]  in_k;
    logic [1:0]       in_l;
    int               nexp;
    logic [2:0][15:0] ex_d;
    logic [2:0][1:0]  ex_k;
    logic [2:0]       ex_l;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tready;
  logic          rand_ready, rnd_ready, man_ready;

  int checks;
  int failures;

  beat_t      got[$];
  beat_t      exp_q[$];
  logic [7:0] pending[$];
  vec_t       vecs[9];

  axis_keep_packer #(.DW(DW), .KW(KW)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tready(m_tready)
  );

  assign m_tready = rand_ready ? rnd_ready : man_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Random downstream ready, changed on the falling edge.
  initial begin
    rnd_ready = 1'b1;
    forever begin
      @(negedge clk);
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor: records every beat that will handshake at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m_tvalid && m_tready) got.push_back('{d: m_tdata, k: m_tkeep, l: m_tlast});
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference model: byte queue per packet, emitting dense beats as they fill.
  function automatic void model_emit(input int n, input logic l);
    beat_t b;
    b = '0;
    for (int j = 0; j < n; j++) begin
      b.d[8*j +: 8] = pending.pop_front();
      b.k[j] = 1'b1;
    end
    b.l = l;
    exp_q.push_back(b);
  endfunction

  function automatic void model_push(input logic [15:0] d, input logic [1:0] k, input logic l);
    for (int i = 0; i < KW; i++) if (k[i]) pending.push_back(d[8*i +: 8]);
    if (!l) begin
      while (pending.size() >= KW) model_emit(KW, 1'b0);
    end else begin
      while (pending.size() > KW) model_emit(KW, 1'b0);
      model_emit(pending.size(), 1'b1);
    end
  endfunction

  // Drive one beat from a falling edge and hold it until it is accepted.
  task automatic apply_stimulus(input logic [15:0] d, input logic [1:0] k, input logic l);
    int budget;
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    #1;
    budget = 200;
    while (!s_tready) begin
      if (budget == 0) begin
        check_output("s_tready timeout", 32'd0, 32'd1);
        break;
      end
      budget--;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    s_tvalid   = 1'b0;
    rand_ready = 1'b0;
    man_ready  = 1'b1;
    repeat (4) @(negedge clk);
    #3;
  endtask

  task automatic compare_queues(input string name);
    check_output({name, " beat count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check_output($sformatf("%s beat %0d", name, i), 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tkeep = '0;
    s_tlast = 1'b0;
    rand_ready = 1'b0;
    man_ready = 1'b1;

    //                 nb in_d                  in_k           in_l  ne ex_d                           ex_k                  ex_l
    vecs[0] = '{2, {16'hC3D4, 16'hA1B2}, {2'b11, 2'b11}, 2'b10, 2, {16'h0000, 16'hC3D4, 16'hA1B2}, {2'b00, 2'b11, 2'b11}, 3'b010};
    vecs[1] = '{2, {16'h00BB, 16'h00AA}, {2'b01, 2'b01}, 2'b10, 1, {16'h0000, 16'h0000, 16'hBBAA}, {2'b00, 2'b00, 2'b11}, 3'b001};
    vecs[2] = '{2, {16'hCCBB, 16'h00AA}, {2'b11, 2'b01}, 2'b10, 2, {16'h0000, 16'h00CC, 16'hBBAA}, {2'b00, 2'b01, 2'b11}, 3'b010};
    vecs[3] = '{2, {16'hFFFF, 16'h1234}, {2'b00, 2'b11}, 2'b10, 2, {16'h0000, 16'h0000, 16'h1234}, {2'b00, 2'b00, 2'b11}, 3'b010};
    vecs[4] = '{2, {16'h6600, 16'h5500}, {2'b10, 2'b10}, 2'b10, 1, {16'h0000, 16'h0000, 16'h6655}, {2'b00, 2'b00, 2'b11}, 3'b001};
    vecs[5] = '{1, {16'h0000, 16'h00EE}, {2'b00, 2'b01}, 2'b01, 1, {16'h0000, 16'h0000, 16'h00EE}, {2'b00, 2'b00, 2'b01}, 3'b001};
    vecs[6] = '{2, {16'h7788, 16'hFFFF}, {2'b11, 2'b00}, 2'b10, 1, {16'h0000, 16'h0000, 16'h7788}, {2'b00, 2'b00, 2'b11}, 3'b001};
    vecs[7] = '{2, {16'h1234, 16'h00AA}, {2'b00, 2'b01}, 2'b10, 1, {16'h0000, 16'h0000, 16'h00AA}, {2'b00, 2'b00, 2'b01}, 3'b001};
    vecs[8] = '{2, {16'h2211, 16'h5500}, {2'b11, 2'b10}, 2'b10, 2, {16'h0000, 16'h0022, 16'h1155}, {2'b00, 2'b01, 2'b11}, 3'b010};

    // Reset state, with downstream ready high to show reset gates s_tready.
    repeat (3) @(negedge clk);
    #1;
    check_output("reset m_tvalid", 32'(m_tvalid), 32'd0);
    check_output("reset m_tdata", 32'(m_tdata), 32'd0);
    check_output("reset m_tkeep", 32'(m_tkeep), 32'd0);
    check_output("reset m_tlast", 32'(m_tlast), 32'd0);
    check_output("reset s_tready", 32'(s_tready), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Dense packet: each output one cycle after its input is accepted.
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = 16'hA1B2; s_tkeep = 2'b11; s_tlast = 1'b0;
    model_push(16'hA1B2, 2'b11, 1'b0);
    #1;
    check_output("dense s_tready", 32'(s_tready), 32'd1);
    @(negedge clk);
    s_tdata = 16'hC3D4; s_tkeep = 2'b11; s_tlast = 1'b1;
    model_push(16'hC3D4, 2'b11, 1'b1);
    #1;
    check_output("dense beat0 latency", {11'd0, m_tvalid, m_tdata, m_tkeep, m_tlast}, {11'd0, 1'b1, 16'hA1B2, 2'b11, 1'b0});
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    check_output("dense beat1 latency", {11'd0, m_tvalid, m_tdata, m_tkeep, m_tlast}, {11'd0, 1'b1, 16'hC3D4, 2'b11, 1'b1});
    drain();
    compare_queues("dense");

    // Residue flush: s_tready low for exactly one cycle while LAST drains.
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = 16'h00AA; s_tkeep = 2'b01; s_tlast = 1'b0;
    model_push(16'h00AA, 2'b01, 1'b0);
    @(negedge clk);
    s_tdata = 16'hCCBB; s_tkeep = 2'b11; s_tlast = 1'b1;
    model_push(16'hCCBB, 2'b11, 1'b1);
    #1;
    check_output("flush accept s_tready", 32'(s_tready), 32'd1);
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    check_output("flush LAST s_tready", 32'(s_tready), 32'd0);
    @(negedge clk);
    #1;
    check_output("flush after LAST s_tready", 32'(s_tready), 32'd1);
    drain();
    compare_queues("flush");

    // Backpressure: output holds and input stalls for five cycles.
    man_ready = 1'b0;
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = 16'h1234; s_tkeep = 2'b11; s_tlast = 1'b0;
    model_push(16'h1234, 2'b11, 1'b0);
    @(negedge clk);
    s_tdata = 16'h00AB; s_tkeep = 2'b01; s_tlast = 1'b1;
    model_push(16'h00AB, 2'b01, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output($sformatf("stall cycle %0d", i),
                   {11'd0, m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready},
                   {11'd0, 1'b1, 16'h1234, 2'b11, 1'b0, 1'b0});
      @(negedge clk);
    end
    man_ready = 1'b1;
    #1;
    check_output("stall release s_tready", 32'(s_tready), 32'd1);
    @(negedge clk);
    s_tvalid = 1'b0;
    drain();
    compare_queues("backpressure");

    // Reset mid-packet: residue byte must be discarded.
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = 16'h00AA; s_tkeep = 2'b01; s_tlast = 1'b0;
    @(negedge clk);
    s_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    check_output("mid reset s_tready", 32'(s_tready), 32'd0);
    @(negedge clk);
    #1;
    check_output("mid reset m_tvalid", 32'(m_tvalid), 32'd0);
    rst = 1'b1;
    model_push(16'h5566, 2'b11, 1'b1);
    apply_stimulus(16'h5566, 2'b11, 1'b1);
    drain();
    compare_queues("after reset");

    // Table vectors with downstream always ready.
    for (int v = 0; v < 9; v++) begin
      for (int b = 0; b < vecs[v].nbeats; b++)
        apply_stimulus(vecs[v].in_d[b], vecs[v].in_k[b], vecs[v].in_l[b]);
      drain();
      for (int e = 0; e < vecs[v].nexp; e++)
        exp_q.push_back('{d: vecs[v].ex_d[e], k: vecs[v].ex_k[e], l: vecs[v].ex_l[e]});
      compare_queues($sformatf("vector %0d", v));
    end

    // Randomized packets with random keeps, gaps and downstream ready.
    rand_ready = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        logic [15:0] d;
        logic [1:0]  k;
        logic        l;
        d = 16'($urandom);
        k = 2'($urandom_range(0, 3));
        l = (b == nb - 1);
        model_push(d, k, l);
        apply_stimulus(d, k, l);
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          s_tvalid = 1'b0;
        end
      end
    end
    drain();
    compare_queues("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
